// File: rtl/riscv_pkg.sv
// Shared RISC-V load definitions: funct3 codes, load metadata record and alignment legality.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } ld_meta_t;

  // Reserved funct3 encodings count as misaligned so they are rejected alongside bad offsets.
  function automatic logic ld_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_LB, F3_LBU: ld_misaligned = 1'b0;
      F3_LH, F3_LHU: ld_misaligned = addr_lo[0];
      F3_LW:         ld_misaligned = (addr_lo != 2'b00);
      default:       ld_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: combinational byte/halfword lane select with sign or zero extension.
// Zero latency; no flow control.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = word_i[{addr_lo_i[1], 4'b0000} +: 16];
    data_o    = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_lane};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: ALU results and in-order load returns share a registered 1-cycle register-file write port;
// load returns win (alu_ready low), ld_req_ready = metadata FIFO not full. WB_MISALIGN_EN rejects misaligned loads.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            RESET,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_req_valid,
  output logic            ld_req_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            WR_EN,
  output logic [4:0]      write_select,
  output logic [XLEN-1:0] data_in,
  output logic [31:0]     busy_mask,
`ifdef WB_MISALIGN_EN
  output logic            ld_misalign,
`endif
  output logic            rsp_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ld_meta_t        meta_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot_off;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;
  ld_meta_t        head, req_meta;
  logic [XLEN-1:0] aligned;
  logic            wr_en_q, wr_en_d, orphan_q, orphan_d;
  logic [4:0]      wr_sel_q, wr_sel_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign ld_req_ready = !full;
  assign alu_ready    = !mem_rsp_valid;
  assign req_meta     = '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};
  assign head         = meta_q[rd_ptr_q];
  // Emptiness is sampled at cycle start, so a same-cycle request cannot satisfy this response.
  assign pop          = mem_rsp_valid && !empty;

`ifdef WB_MISALIGN_EN
  logic req_bad, misalign_q, misalign_d;
  assign req_bad     = ld_misaligned(ld_funct3, ld_addr_lo);
  assign push        = ld_req_valid && ld_req_ready && !req_bad;
  assign misalign_d  = ld_req_valid && ld_req_ready && req_bad;
  assign ld_misalign = misalign_q;

  always_ff @(posedge clock or posedge RESET) begin
    if (RESET) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`else
  assign push = ld_req_valid && ld_req_ready;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) meta_q[wr_ptr_q] <= req_meta;
  end

  always_comb begin
    busy_mask = '0;
    slot_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if (CW'(slot_off) < count_q) busy_mask[meta_q[i].rd] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i  (head.funct3),
    .addr_lo_i (head.addr_lo),
    .word_i    (mem_rsp_data),
    .data_o    (aligned)
  );

  always_comb begin
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    orphan_d  = orphan_q;
    if (mem_rsp_valid) begin
      if (!empty) begin
        wr_en_d   = (head.rd != 5'd0);
        wr_sel_d  = head.rd;
        wr_data_d = aligned;
      end else begin
        orphan_d  = 1'b1;
      end
    end else if (alu_valid) begin
      wr_en_d   = (alu_rd != 5'd0);
      wr_sel_d  = alu_rd;
      wr_data_d = alu_data;
    end
  end

  always_ff @(posedge clock or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      orphan_q  <= orphan_d;
    end
  end

  assign WR_EN        = wr_en_q;
  assign write_select = wr_sel_q;
  assign data_in      = wr_data_q;
  assign rsp_orphan   = orphan_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_writeback_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            RESET;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_req_valid, ld_req_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            WR_EN;
  logic [4:0]      write_select;
  logic [XLEN-1:0] data_in;
  logic [31:0]     busy_mask;
  logic            rsp_orphan;
`ifdef WB_MISALIGN_EN
  logic            ld_misalign;
`endif

  writeback_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .RESET         (RESET),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_req_valid  (ld_req_valid),
    .ld_req_ready  (ld_req_ready),
    .ld_rd         (ld_rd),
    .ld_funct3     (ld_funct3),
    .ld_addr_lo    (ld_addr_lo),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .WR_EN         (WR_EN),
    .write_select  (write_select),
    .data_in       (data_in),
    .busy_mask     (busy_mask),
`ifdef WB_MISALIGN_EN
    .ld_misalign   (ld_misalign),
`endif
    .rsp_orphan    (rsp_orphan)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ent_t;

  ent_t        q[$];
  logic        m_en, m_orphan;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> ((lo >= 2'd2) ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b > 32'd127) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h > 32'd32767) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_busy();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) if (q[i].rd != 5'd0) m[q[i].rd] = 1'b1;
    return m;
  endfunction

`ifdef WB_MISALIGN_EN
  function automatic bit ref_reject(input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return lo[0];
    if (f3 == 3'd2) return lo != 2'd0;
    return 1'b1;
  endfunction
`endif

  task automatic model_reset();
    q.delete();
    m_en = 1'b0; m_sel = '0; m_data = '0; m_orphan = 1'b0;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_req_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  // Advance the reference model by the current inputs, then take one clock edge.
  task automatic tick();
    bit   do_push;
    ent_t e;
    if (RESET) begin
      model_reset();
    end else begin
      do_push = ld_req_valid && (q.size() < DEPTH);
`ifdef WB_MISALIGN_EN
      if (ref_reject(ld_funct3, ld_addr_lo)) do_push = 1'b0;
`endif
      m_en = 1'b0;
      if (mem_rsp_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_en = (e.rd != 5'd0); m_sel = e.rd; m_data = ref_align(e.f3, e.lo, mem_rsp_data);
        end else begin
          m_orphan = 1'b1;
        end
      end else if (alu_valid) begin
        m_en = (alu_rd != 5'd0); m_sel = alu_rd; m_data = alu_data;
      end
      if (do_push) begin
        e.rd = ld_rd; e.f3 = ld_funct3; e.lo = ld_addr_lo;
        q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    ld_req_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo;
    tick();
    ld_req_valid = 1'b0;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    tests++; if (WR_EN !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %0b want 0", WR_EN); end
    tests++; if (write_select !== 5'd0) begin fails++; $display("FAIL reset_sel: got %0d want 0", write_select); end
    tests++; if (data_in !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", data_in); end
    tests++; if (rsp_orphan !== 1'b0) begin fails++; $display("FAIL reset_orphan: got %0b want 0", rsp_orphan); end
    tests++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
    tests++; if (ld_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", ld_req_ready); end
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_lb();
    issue_load(5'd5, 3'd0, 2'd3);
    #1;
    tests++; if (busy_mask !== 32'h20) begin fails++; $display("FAIL lb_busy_set: got %h want 00000020", busy_mask); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h80AA_BBCC;
    #1;
    tests++; if (busy_mask !== 32'h20) begin fails++; $display("FAIL lb_busy_rsp: got %h want 00000020", busy_mask); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    tests++; if (WR_EN !== 1'b1) begin fails++; $display("FAIL lb_wr_en: got %0b want 1", WR_EN); end
    tests++; if (write_select !== 5'd5) begin fails++; $display("FAIL lb_sel: got %0d want 5", write_select); end
    tests++; if (data_in !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data: got %h want ffffff80", data_in); end
    tests++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL lb_busy_clr: got %h want 0", busy_mask); end
  endtask

  task automatic test_halfword();
    issue_load(5'd7, 3'd5, 2'd2);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF_1234;
    tick();
    mem_rsp_valid = 1'b0;
    tests++; if (data_in !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_data: got %h want 0000beef", data_in); end
    tests++; if (write_select !== 5'd7) begin fails++; $display("FAIL lhu_sel: got %0d want 7", write_select); end
    issue_load(5'd7, 3'd1, 2'd2);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF_1234;
    tick();
    mem_rsp_valid = 1'b0;
    tests++; if (data_in !== 32'hFFFF_BEEF) begin fails++; $display("FAIL lh_data: got %h want ffffbeef", data_in); end
  endtask

  task automatic test_alu_conflict();
    issue_load(5'd4, 3'd2, 2'd0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    #1;
    tests++; if (alu_ready !== 1'b0) begin fails++; $display("FAIL conflict_alu_ready: got %0b want 0", alu_ready); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL conflict_alu_ready2: got %0b want 1", alu_ready); end
    tests++; if ({WR_EN, write_select, data_in} !== {1'b1, 5'd4, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL conflict_first: got en=%0b sel=%0d data=%h want en=1 sel=4 data=deadbeef", WR_EN, write_select, data_in);
    end
    tick();
    alu_valid = 1'b0;
    tests++; if ({WR_EN, write_select, data_in} !== {1'b1, 5'd3, 32'h1234}) begin
      fails++; $display("FAIL conflict_second: got en=%0b sel=%0d data=%h want en=1 sel=3 data=00001234", WR_EN, write_select, data_in);
    end
    tick();
    tests++; if ({WR_EN, write_select, data_in} !== {1'b0, 5'd3, 32'h1234}) begin
      fails++; $display("FAIL idle_hold: got en=%0b sel=%0d data=%h want en=0 sel=3 data=00001234", WR_EN, write_select, data_in);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) issue_load(5'(8 + i), 3'd2, 2'd0);
    #1;
    tests++; if (ld_req_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0b want 0", ld_req_ready); end
    tests++; if (busy_mask !== 32'h0000_0F00) begin fails++; $display("FAIL full_busy: got %h want 00000f00", busy_mask); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1000;
    ld_req_valid = 1'b1; ld_rd = 5'd12; ld_funct3 = 3'd2; ld_addr_lo = 2'd0;
    #1;
    tests++; if (ld_req_ready !== 1'b0) begin fails++; $display("FAIL full_pop_ready: got %0b want 0", ld_req_ready); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    tests++; if (ld_req_ready !== 1'b1) begin fails++; $display("FAIL full_after_pop_ready: got %0b want 1", ld_req_ready); end
    tests++; if (write_select !== 5'd8) begin fails++; $display("FAIL full_first_sel: got %0d want 8", write_select); end
    tick();
    ld_req_valid = 1'b0;
    #1;
    tests++; if (busy_mask !== 32'h0000_1E00) begin fails++; $display("FAIL full_busy2: got %h want 00001e00", busy_mask); end
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2000 + 32'(k);
      tick();
      tests++; if ({WR_EN, write_select, data_in} !== {1'b1, 5'(9 + k), 32'h2000 + 32'(k)}) begin
        fails++; $display("FAIL full_drain_%0d: got en=%0b sel=%0d data=%h want en=1 sel=%0d data=%h", k, WR_EN, write_select, data_in, 9 + k, 32'h2000 + k);
      end
    end
    mem_rsp_valid = 1'b0;
    #1;
    tests++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL full_busy_empty: got %h want 0", busy_mask); end
  endtask

  task automatic test_x0_orphan();
    issue_load(5'd0, 3'd2, 2'd0);
    #1;
    tests++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL x0_busy: got %h want 0", busy_mask); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555;
    tick();
    mem_rsp_valid = 1'b0;
    tests++; if (WR_EN !== 1'b0) begin fails++; $display("FAIL x0_wr_en: got %0b want 0", WR_EN); end
    tests++; if (rsp_orphan !== 1'b0) begin fails++; $display("FAIL x0_not_orphan: got %0b want 0", rsp_orphan); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777;
    tick();
    mem_rsp_valid = 1'b0;
    tests++; if (rsp_orphan !== 1'b1) begin fails++; $display("FAIL orphan_set: got %0b want 1", rsp_orphan); end
    tests++; if (WR_EN !== 1'b0) begin fails++; $display("FAIL orphan_wr_en: got %0b want 0", WR_EN); end
    repeat (3) tick();
    tests++; if (rsp_orphan !== 1'b1) begin fails++; $display("FAIL orphan_sticky: got %0b want 1", rsp_orphan); end
  endtask

  task automatic test_reset_mid();
    issue_load(5'd13, 3'd2, 2'd0);
    issue_load(5'd14, 3'd2, 2'd0);
    #1;
    tests++; if (busy_mask !== 32'h0000_6000) begin fails++; $display("FAIL mid_busy: got %h want 00006000", busy_mask); end
    RESET = 1'b1;
    #1;
    tests++; if ({WR_EN, write_select, data_in, rsp_orphan, busy_mask} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: got en=%0b sel=%0d data=%h orphan=%0b busy=%h want all 0", WR_EN, write_select, data_in, rsp_orphan, busy_mask);
    end
    tick();
    RESET = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA;
    tick();
    mem_rsp_valid = 1'b0;
    tests++; if (rsp_orphan !== 1'b1) begin fails++; $display("FAIL mid_orphan: got %0b want 1", rsp_orphan); end
    tests++; if (WR_EN !== 1'b0) begin fails++; $display("FAIL mid_wr_en: got %0b want 0", WR_EN); end
  endtask

  task automatic test_random();
    bit stalled;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      stalled = alu_valid && mem_rsp_valid;
      if (!stalled) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      ld_req_valid  = ($urandom_range(0, 2) == 0);
      ld_rd         = 5'($urandom_range(0, 31));
      ld_funct3     = 3'($urandom_range(0, 7));
      ld_addr_lo    = 2'($urandom_range(0, 3));
      mem_rsp_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rsp_data  = $urandom;
      #1;
      tests++; if (alu_ready !== !mem_rsp_valid) begin fails++; $display("FAIL rnd_alu_ready c=%0d: got %0b want %0b", c, alu_ready, !mem_rsp_valid); end
      tests++; if (ld_req_ready !== (q.size() < DEPTH)) begin fails++; $display("FAIL rnd_ld_ready c=%0d: got %0b want %0b", c, ld_req_ready, q.size() < DEPTH); end
      tests++; if (busy_mask !== ref_busy()) begin fails++; $display("FAIL rnd_busy c=%0d: got %h want %h", c, busy_mask, ref_busy()); end
      tick();
      tests++; if ({WR_EN, write_select, data_in, rsp_orphan} !== {m_en, m_sel, m_data, m_orphan}) begin
        fails++; $display("FAIL rnd_write c=%0d: got en=%0b sel=%0d data=%h orphan=%0b want en=%0b sel=%0d data=%h orphan=%0b",
                          c, WR_EN, write_select, data_in, rsp_orphan, m_en, m_sel, m_data, m_orphan);
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_halfword();
    test_alu_conflict();
    test_full();
    test_x0_orphan();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
